// File: rtl/sent_rx_frame_ctrl.sv
// SENT receive frame controller: calibration handshake, frame sequencing,
// pulse-to-nibble decode, 4-bit CRC check and lock tracking.
module sent_rx_frame_ctrl #(
  parameter int unsigned DATA_NIBBLES = 6,
  parameter bit          PAUSE_EN     = 1'b0,
  parameter int unsigned LOCK_FRAMES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cal_done,
  input  logic        pulse_valid,
  input  logic [9:0]  pulse_ticks,
  output logic        cal_req,
  output logic        frame_valid,
  output logic [3:0]  status_nibble,
  output logic [23:0] data_out,
  output logic        crc_ok,
  output logic        error,
  output logic [2:0]  error_code,
  output logic        locked
);

  localparam int unsigned ALIGN_SHIFT = 4 * (6 - DATA_NIBBLES);
  localparam logic [2:0]  LAST_NIB    = 3'(DATA_NIBBLES - 1);
  localparam logic [3:0]  CRC_SEED    = 4'b0101;
  localparam logic [3:0]  CRC_POLY    = 4'b1101;
  localparam logic [2:0]  ERR_NIBBLE  = 3'd1;
  localparam logic [2:0]  ERR_SYNC    = 3'd2;
  localparam logic [2:0]  ERR_CRC     = 3'd3;
  localparam logic [2:0]  ERR_PAUSE   = 3'd4;

  typedef enum logic [2:0] {
    ST_HUNT, ST_STATUS, ST_DATA, ST_CRC, ST_PAUSE, ST_SYNC
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  nib_cnt_q, nib_cnt_d;
  logic [3:0]  crc_q, crc_d;
  logic [3:0]  status_acc_q, status_acc_d;
  logic [23:0] data_acc_q, data_acc_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d;
  logic        cal_req_q, cal_req_d;
  logic        frame_valid_q, frame_valid_d;
  logic [3:0]  status_nibble_q, status_nibble_d;
  logic [23:0] data_out_q, data_out_d;
  logic        crc_ok_q, crc_ok_d;
  logic        error_q, error_d;
  logic [2:0]  error_code_q, error_code_d;
  logic        locked_q, locked_d;

  logic        nib_legal, pause_legal, sync_legal;
  logic [3:0]  nib_val;
  logic [3:0]  crc_expect;
  logic        proto_err;
  logic [2:0]  proto_code;

  // Fold one nibble into the CRC, MSB first.
  function automatic logic [3:0] crc_fold(input logic [3:0] crc, input logic [3:0] nib);
    logic [3:0] c;
    logic       fb;
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      fb = c[3];
      c  = {c[2:0], nib[i]};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

  assign nib_legal   = (pulse_ticks >= 10'd12) && (pulse_ticks <= 10'd27);
  assign pause_legal = (pulse_ticks >= 10'd12) && (pulse_ticks <= 10'd768);
  assign sync_legal  = (pulse_ticks >= 10'd55) && (pulse_ticks <= 10'd57);
  assign nib_val     = 4'(pulse_ticks - 10'd12);
  assign crc_expect  = crc_fold(crc_q, 4'd0);

  // Next-state, frame assembly and output computation.
  always_comb begin
    state_d         = state_q;
    nib_cnt_d       = nib_cnt_q;
    crc_d           = crc_q;
    status_acc_d    = status_acc_q;
    data_acc_d      = data_acc_q;
    lock_cnt_d      = lock_cnt_q;
    frame_valid_d   = 1'b0;
    status_nibble_d = status_nibble_q;
    data_out_d      = data_out_q;
    crc_ok_d        = crc_ok_q;
    error_d         = 1'b0;
    error_code_d    = error_code_q;
    proto_err       = 1'b0;
    proto_code      = ERR_NIBBLE;

    unique case (state_q)
      ST_HUNT: begin
        if (cal_done) state_d = ST_STATUS;
      end
      ST_STATUS: begin
        if (pulse_valid) begin
          if (nib_legal) begin
            status_acc_d = nib_val;
            crc_d        = CRC_SEED;
            data_acc_d   = '0;
            nib_cnt_d    = '0;
            state_d      = ST_DATA;
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (pulse_valid) begin
          if (nib_legal) begin
            data_acc_d = {data_acc_q[19:0], nib_val};
            crc_d      = crc_fold(crc_q, nib_val);
            if (nib_cnt_q == LAST_NIB) state_d = ST_CRC;
            else nib_cnt_d = nib_cnt_q + 3'd1;
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      ST_CRC: begin
        if (pulse_valid) begin
          if (nib_legal) begin
            frame_valid_d   = 1'b1;
            status_nibble_d = status_acc_q;
            data_out_d      = data_acc_q << ALIGN_SHIFT;
            crc_ok_d        = (nib_val == crc_expect);
            if (nib_val == crc_expect) begin
              lock_cnt_d = (lock_cnt_q == 4'd15) ? 4'd15 : lock_cnt_q + 4'd1;
            end else begin
              error_d      = 1'b1;
              error_code_d = ERR_CRC;
              lock_cnt_d   = '0;
            end
            state_d = PAUSE_EN ? ST_PAUSE : ST_SYNC;
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (pulse_valid) begin
          if (pause_legal) state_d = ST_SYNC;
          else begin
            proto_err  = 1'b1;
            proto_code = ERR_PAUSE;
          end
        end
      end
      ST_SYNC: begin
        if (pulse_valid) begin
          if (sync_legal) state_d = ST_STATUS;
          else begin
            proto_err  = 1'b1;
            proto_code = ERR_SYNC;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Protocol errors abandon the frame and restart calibration.
    if (proto_err) begin
      error_d      = 1'b1;
      error_code_d = proto_code;
      lock_cnt_d   = '0;
      state_d      = ST_HUNT;
    end

    cal_req_d = (state_d == ST_HUNT);
    locked_d  = (32'(lock_cnt_d) >= LOCK_FRAMES);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_HUNT;
      nib_cnt_q       <= '0;
      crc_q           <= '0;
      status_acc_q    <= '0;
      data_acc_q      <= '0;
      lock_cnt_q      <= '0;
      cal_req_q       <= 1'b0;
      frame_valid_q   <= 1'b0;
      status_nibble_q <= '0;
      data_out_q      <= '0;
      crc_ok_q        <= 1'b0;
      error_q         <= 1'b0;
      error_code_q    <= '0;
      locked_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      nib_cnt_q       <= nib_cnt_d;
      crc_q           <= crc_d;
      status_acc_q    <= status_acc_d;
      data_acc_q      <= data_acc_d;
      lock_cnt_q      <= lock_cnt_d;
      cal_req_q       <= cal_req_d;
      frame_valid_q   <= frame_valid_d;
      status_nibble_q <= status_nibble_d;
      data_out_q      <= data_out_d;
      crc_ok_q        <= crc_ok_d;
      error_q         <= error_d;
      error_code_q    <= error_code_d;
      locked_q        <= locked_d;
    end
  end

  assign cal_req       = cal_req_q;
  assign frame_valid   = frame_valid_q;
  assign status_nibble = status_nibble_q;
  assign data_out      = data_out_q;
  assign crc_ok        = crc_ok_q;
  assign error         = error_q;
  assign error_code    = error_code_q;
  assign locked        = locked_q;

endmodule

// File: tb/tb_sent_rx_frame_ctrl.sv
// Bench for sent_rx_frame_ctrl: directed vector table, hand sequences and
// random traffic against a frame-level reference model, on two configurations.
module tb_sent_rx_frame_ctrl;

  logic        clk;
  logic        reset;
  logic        cal_done;
  logic        pulse_valid;
  logic [9:0]  pulse_ticks;

  logic        a_cal, a_fv, a_ok, a_err, a_lock;
  logic [3:0]  a_st;
  logic [23:0] a_data;
  logic [2:0]  a_code;
  logic        b_cal, b_fv, b_ok, b_err, b_lock;
  logic [3:0]  b_st;
  logic [23:0] b_data;
  logic [2:0]  b_code;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sent_rx_frame_ctrl #(.DATA_NIBBLES(6), .PAUSE_EN(1'b0), .LOCK_FRAMES(4)) u_dut_a (
    .clk(clk), .reset(reset), .cal_done(cal_done), .pulse_valid(pulse_valid),
    .pulse_ticks(pulse_ticks), .cal_req(a_cal), .frame_valid(a_fv),
    .status_nibble(a_st), .data_out(a_data), .crc_ok(a_ok), .error(a_err),
    .error_code(a_code), .locked(a_lock));

  sent_rx_frame_ctrl #(.DATA_NIBBLES(3), .PAUSE_EN(1'b1), .LOCK_FRAMES(1)) u_dut_b (
    .clk(clk), .reset(reset), .cal_done(cal_done), .pulse_valid(pulse_valid),
    .pulse_ticks(pulse_ticks), .cal_req(b_cal), .frame_valid(b_fv),
    .status_nibble(b_st), .data_out(b_data), .crc_ok(b_ok), .error(b_err),
    .error_code(b_code), .locked(b_lock));

  logic [35:0] pack_a, pack_b;
  assign pack_a = {a_cal, a_fv, a_st, a_data, a_ok, a_err, a_code, a_lock};
  assign pack_b = {b_cal, b_fv, b_st, b_data, b_ok, b_err, b_code, b_lock};

  // Reference model: tracks position within the frame and the collected nibbles.
  int          dn_of  [2] = '{6, 3};
  bit          pen_of [2] = '{1'b0, 1'b1};
  int          lf_of  [2] = '{4, 1};
  bit          m_hunt [2];
  int          m_pos  [2];
  int          m_lock [2];
  logic [3:0]  m_stat [2];
  logic [23:0] m_data [2];
  logic        e_cal [2], e_fv [2], e_ok [2], e_err [2], e_lock [2];
  logic [3:0]  e_st [2];
  logic [23:0] e_data [2];
  logic [2:0]  e_code [2];

  // CRC as polynomial remainder of {0101, data nibbles, 0000} mod x^4+x^3+x^2+1.
  function automatic logic [3:0] crc_ref(input logic [23:0] d, input int n);
    logic [63:0] v;
    v = 64'h5;
    for (int i = 0; i < n; i++) v = (v << 4) | 64'((d >> (20 - 4 * i)) & 24'hF);
    v = v << 4;
    for (int b = 63; b >= 4; b--) if (v[b]) v = v ^ (64'h1D << (b - 4));
    return v[3:0];
  endfunction

  task automatic mfail(input int k, input int c);
    e_err[k]  = 1'b1;
    e_code[k] = 3'(c);
    m_lock[k] = 0;
    m_hunt[k] = 1'b1;
  endtask

  task automatic mstep(input int k, input bit rst, input bit cd, input bit pv, input int t);
    int dn;
    dn = dn_of[k];
    e_fv[k]  = 1'b0;
    e_err[k] = 1'b0;
    if (rst) begin
      m_hunt[k] = 1'b1; m_pos[k] = 0; m_lock[k] = 0; m_stat[k] = '0; m_data[k] = '0;
      e_cal[k] = 1'b0; e_ok[k] = 1'b0; e_st[k] = '0; e_data[k] = '0;
      e_code[k] = '0; e_lock[k] = 1'b0;
      return;
    end
    if (m_hunt[k]) begin
      if (cd) begin
        m_hunt[k] = 1'b0;
        m_pos[k]  = 0;
      end
    end else if (pv) begin
      if (m_pos[k] <= dn + 1) begin
        if (t < 12 || t > 27) mfail(k, 1);
        else if (m_pos[k] == 0) begin
          m_stat[k] = 4'(t - 12);
          m_data[k] = '0;
          m_pos[k]  = 1;
        end else if (m_pos[k] <= dn) begin
          m_data[k] = m_data[k] | (24'(t - 12) << (24 - 4 * m_pos[k]));
          m_pos[k]  = m_pos[k] + 1;
        end else begin
          e_fv[k]   = 1'b1;
          e_st[k]   = m_stat[k];
          e_data[k] = m_data[k];
          e_ok[k]   = (4'(t - 12) == crc_ref(m_data[k], dn));
          if (e_ok[k]) m_lock[k] = (m_lock[k] >= 15) ? 15 : m_lock[k] + 1;
          else begin
            e_err[k]  = 1'b1;
            e_code[k] = 3'd3;
            m_lock[k] = 0;
          end
          m_pos[k] = dn + 2;
        end
      end else if (pen_of[k] && m_pos[k] == dn + 2) begin
        if (t >= 12 && t <= 768) m_pos[k] = m_pos[k] + 1;
        else mfail(k, 4);
      end else begin
        if (t >= 55 && t <= 57) m_pos[k] = 0;
        else mfail(k, 2);
      end
    end
    e_cal[k]  = m_hunt[k];
    e_lock[k] = (m_lock[k] >= lf_of[k]);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit cd, input bit pv, input int t);
    reset       = rst;
    cal_done    = cd;
    pulse_valid = pv;
    pulse_ticks = 10'(t);
    for (int k = 0; k < 2; k++) mstep(k, rst, cd, pv, t);
    @(posedge clk);
    #1;
    chk("model_a", 64'(pack_a), 64'({e_cal[0], e_fv[0], e_st[0], e_data[0], e_ok[0], e_err[0], e_code[0], e_lock[0]}));
    chk("model_b", 64'(pack_b), 64'({e_cal[1], e_fv[1], e_st[1], e_data[1], e_ok[1], e_err[1], e_code[1], e_lock[1]}));
    reset       = 1'b0;
    cal_done    = 1'b0;
    pulse_valid = 1'b0;
  endtask

  // Back-to-back status, data and CRC pulses; random nibbles, optional CRC corruption.
  task automatic send_frame(input int dn, input bit corrupt);
    logic [23:0] d;
    logic [3:0]  c;
    int          nib;
    d = '0;
    cycle(1'b0, 1'b0, 1'b1, int'($urandom_range(27, 12)));
    for (int i = 0; i < dn; i++) begin
      nib = int'($urandom_range(15, 0));
      d   = d | (24'(nib) << (20 - 4 * i));
      cycle(1'b0, 1'b0, 1'b1, nib + 12);
    end
    c = crc_ref(d, dn);
    if (corrupt) c = c + 4'd1;
    cycle(1'b0, 1'b0, 1'b1, int'(c) + 12);
  endtask

  typedef struct {
    bit rst; bit cd; bit pv; int t;
    bit fv; bit ok; bit err; logic [2:0] code; bit cal; bit lck;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input bit rst, input bit cd, input bit pv, input int t,
                              input bit fv, input bit ok, input bit err, input int code,
                              input bit cal, input bit lck);
    vec_t v;
    v.rst = rst; v.cd = cd; v.pv = pv; v.t = t;
    v.fv = fv; v.ok = ok; v.err = err; v.code = 3'(code); v.cal = cal; v.lck = lck;
    return v;
  endfunction

  initial begin
    reset = 1'b1; cal_done = 1'b0; pulse_valid = 1'b0; pulse_ticks = '0;

    // Directed table (expectations for the 6-nibble, no-pause configuration).
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 0, 1, 12, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 17, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 56, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 0, 1, 12, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 18, 1, 0, 1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 56, 0, 0, 0, 3, 0, 0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 0, 1, 12, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 17, 1, 1, 0, 3, 0, 0));
    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].cd, vecs[i].pv, vecs[i].t);
      chk("vec_a", 64'({a_fv, a_ok, a_err, a_code, a_cal, a_lock, a_st, a_data}),
          64'({vecs[i].fv, vecs[i].ok, vecs[i].err, vecs[i].code, vecs[i].cal, vecs[i].lck, 4'd0, 24'd0}));
    end

    // Lock after the fourth good frame, lost on an illegal data pulse.
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 1, 0, 0);
    for (int f = 1; f <= 5; f++) begin
      send_frame(6, 1'b0);
      chk("lock_frame", 64'(a_lock), 64'(f >= 4));
      cycle(0, 0, 1, 56);
    end
    cycle(0, 0, 1, 12);
    cycle(0, 0, 1, 28);
    chk("bad_nib_err", 64'({a_err, a_code, a_lock, a_cal}), 64'({1'b1, 3'd1, 1'b0, 1'b1}));

    // Pause handling on the 3-nibble configuration.
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 1, 0, 0);
    send_frame(3, 1'b0);
    chk("pause_frame", 64'({b_fv, b_ok, b_err}), 64'({1'b1, 1'b1, 1'b0}));
    cycle(0, 0, 1, 200);
    chk("pause_ok", 64'(b_err), 64'(0));
    cycle(0, 0, 1, 56);
    chk("pause_sync_ok", 64'(b_err), 64'(0));
    send_frame(3, 1'b0);
    cycle(0, 0, 1, 800);
    chk("pause_long", 64'({b_err, b_code, b_cal}), 64'({1'b1, 3'd4, 1'b1}));

    // Bad sync, ignored pulses in HUNT, cal_done beating a same-cycle pulse.
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 1, 0, 0);
    send_frame(6, 1'b0);
    cycle(0, 0, 1, 60);
    chk("sync_bad", 64'({a_err, a_code, a_cal}), 64'({1'b1, 3'd2, 1'b1}));
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 12 + i);
      chk("hunt_quiet", 64'({a_fv, a_err, a_cal}), 64'({1'b0, 1'b0, 1'b1}));
    end
    cycle(0, 1, 1, 12);
    chk("cal_wins", 64'({a_cal, a_err}), 64'({1'b0, 1'b0}));
    send_frame(6, 1'b0);
    chk("after_cal", 64'({a_fv, a_ok, a_err}), 64'({1'b1, 1'b1, 1'b0}));

    // Reset in the middle of a frame.
    cycle(0, 0, 1, 56);
    cycle(0, 0, 1, 20);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 13 + i);
    cycle(1, 0, 1, 14);
    chk("mid_reset", 64'(pack_a), 64'(0));
    cycle(0, 0, 0, 0);
    chk("post_reset", 64'({a_cal, a_fv}), 64'({1'b1, 1'b0}));

    // Random traffic checked against the model.
    for (int it = 0; it < 400; it++) begin
      int sel;
      sel = int'($urandom_range(9, 0));
      if (sel < 3) begin
        send_frame(6, $urandom_range(3, 0) == 0);
        cycle(0, 0, 1, int'($urandom_range(57, 55)));
      end else if (sel < 5) begin
        send_frame(3, $urandom_range(3, 0) == 0);
        cycle(0, 0, 1, int'($urandom_range(768, 12)));
        cycle(0, 0, 1, int'($urandom_range(57, 55)));
      end else if (sel == 5) begin
        cycle(0, 1, 1'($urandom_range(1, 0)), int'($urandom_range(27, 12)));
      end else if (sel == 6) begin
        cycle(1'($urandom_range(7, 0) == 0), 0, 1, int'($urandom_range(27, 12)));
      end else begin
        cycle(0, 1'($urandom_range(9, 0) == 0), 1'($urandom_range(1, 0)),
              int'($urandom_range(1023, 0)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
